// File: rtl/jts16b_bus_pkg.sv
// Shared types and helpers for the 68000 bus-cycle arbiter.
package jts16b_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } state_t;

  localparam int unsigned TOUT_DEFAULT = 255;

  function automatic logic [15:0] onehot(input logic [3:0] idx, input int unsigned nreg);
    logic [15:0] v;
    v = '0;
    if (32'(idx) < nreg) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/jts16b_prienc.sv
// Lowest-index-wins priority encoder over NREG request bits.
module jts16b_prienc #(
  parameter int unsigned NREG = 8
) (
  input  logic [NREG-1:0] req,
  output logic [3:0]      idx,
  output logic            hit
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = NREG; i > 0; i--) begin
      if (req[i-1]) begin
        idx = 4'(i - 1);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jts16b_bus_arb.sv
// Chip-select, read-data mux, DTACKn and timeout BERRn for the 68000 bus.
module jts16b_bus_arb
  import jts16b_bus_pkg::*;
#(
  parameter int unsigned     NREG     = 8,
  parameter int unsigned     DW       = 16,
  parameter logic [NREG-1:0] FASTMASK = '0,
  parameter int unsigned     TOUT     = TOUT_DEFAULT,
  parameter int unsigned     CW       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ASn,
  input  logic             UDSn,
  input  logic             LDSn,
  input  logic             BGACKn,
  input  logic [NREG-1:0]  active,
  input  logic [NREG-1:0]  region_ok,
  input  logic [NREG*DW-1:0] region_din,
  output logic [NREG-1:0]  cs,
  output logic [DW-1:0]    cpu_din,
  output logic             DTACKn,
  output logic             BERRn,
  output logic [3:0]       sel,
  output logic             busy
);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREG-1:0] cs_nxt;
  logic [DW-1:0]   din_nxt;
  logic            dtackn_nxt, berrn_nxt;
  logic [3:0]      sel_nxt;
  logic [3:0]      pri_idx;
  logic            pri_hit;
  logic [15:0]     oh;
  logic            bus_n, start, granted, tout_hit;

  jts16b_prienc #(.NREG(NREG)) u_prienc (
    .req (active),
    .idx (pri_idx),
    .hit (pri_hit)
  );

  assign bus_n    = ASn | (UDSn & LDSn);
  assign start    = ~bus_n & BGACKn;
  assign oh       = onehot(pri_idx, NREG);
  // An unmapped cycle holds cs at zero, so it can never be granted.
  assign granted  = |(cs & (region_ok | FASTMASK));
  assign tout_hit = (cnt == CW'(TOUT));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cs      <= '0;
      cpu_din <= '1;
      DTACKn  <= 1'b1;
      BERRn   <= 1'b1;
      sel     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cs      <= cs_nxt;
      cpu_din <= din_nxt;
      DTACKn  <= dtackn_nxt;
      BERRn   <= berrn_nxt;
      sel     <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (granted)       state_nxt = ST_ACK;
        else if (bus_n)    state_nxt = ST_IDLE;
        else if (tout_hit) state_nxt = ST_BERR;
      end
      ST_ACK:  if (bus_n) state_nxt = ST_IDLE;
      ST_BERR: if (ASn)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_nxt     = cs;
    din_nxt    = cpu_din;
    dtackn_nxt = DTACKn;
    berrn_nxt  = BERRn;
    sel_nxt    = sel;
    cnt_nxt    = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cs_nxt  = pri_hit ? oh[NREG-1:0] : '0;
          sel_nxt = pri_idx;
          cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (granted) begin
          din_nxt    = region_din[32'(sel)*DW +: DW];
          dtackn_nxt = 1'b0;
        end else if (bus_n) begin
          cs_nxt = '0;
        end else if (tout_hit) begin
          berrn_nxt = 1'b0;
          cs_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_ACK: begin
        if (bus_n) begin
          cs_nxt     = '0;
          dtackn_nxt = 1'b1;
        end
      end
      ST_BERR: if (ASn) berrn_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jts16b_bus_arb.sv
// Bench for jts16b_bus_arb: directed vector table, corner sequences, random vs. model.
module tb_jts16b_bus_arb;

  localparam int unsigned NREG = 8;
  localparam int unsigned DW   = 16;
  localparam logic [7:0]  FAST = 8'h40;
  localparam int          TOUT = 16;

  logic         clk = 1'b0;
  logic         rst, ASn, UDSn, LDSn, BGACKn;
  logic [7:0]   active, region_ok;
  logic [127:0] region_din;
  logic [7:0]   cs;
  logic [15:0]  cpu_din;
  logic         DTACKn, BERRn, busy;
  logic [3:0]   sel;

  int vectors = 0;
  int miscompares = 0;

  jts16b_bus_arb #(
    .NREG(NREG), .DW(DW), .FASTMASK(FAST), .TOUT(TOUT), .CW(10)
  ) dut (
    .clk(clk), .rst(rst), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .BGACKn(BGACKn),
    .active(active), .region_ok(region_ok), .region_din(region_din),
    .cs(cs), .cpu_din(cpu_din), .DTACKn(DTACKn), .BERRn(BERRn), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the bus cycle as a transaction (who owns it, how old it is).
  bit         m_pending = 0, m_acked = 0, m_errored = 0;
  int         m_owner = -1, m_age = 0, m_sel = 0;
  logic [7:0] m_cs = '0;
  logic [15:0] m_din = 16'hFFFF;
  logic       m_dtn = 1'b1, m_ben = 1'b1;

  always @(posedge clk) begin
    bit req;
    req = !ASn && !(UDSn && LDSn);
    if (rst) begin
      m_pending = 0; m_acked = 0; m_errored = 0; m_owner = -1; m_age = 0;
      m_sel = 0; m_cs = '0; m_din = 16'hFFFF; m_dtn = 1'b1; m_ben = 1'b1;
    end else if (m_errored) begin
      if (ASn) begin m_errored = 0; m_ben = 1'b1; end
    end else if (m_acked) begin
      if (!req) begin m_acked = 0; m_cs = '0; m_dtn = 1'b1; end
    end else if (m_pending) begin
      if (m_owner >= 0 && (region_ok[m_owner] || FAST[m_owner])) begin
        m_pending = 0; m_acked = 1; m_dtn = 1'b0;
        m_din = region_din[m_owner*16 +: 16];
      end else if (!req) begin
        m_pending = 0; m_cs = '0;
      end else if (m_age == TOUT) begin
        m_pending = 0; m_errored = 1; m_ben = 1'b0; m_cs = '0;
      end else begin
        m_age++;
      end
    end else if (req && BGACKn) begin
      m_pending = 1; m_age = 0; m_owner = -1;
      for (int i = 7; i >= 0; i--) if (active[i]) m_owner = i;
      m_cs  = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      m_sel = (m_owner >= 0) ? m_owner : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 0; ASn = 1; UDSn = 1; LDSn = 1; BGACKn = 1; active = '0; region_ok = '0;
  endtask

  typedef struct {
    logic rst, asn, udsn, ldsn, bgackn;
    logic [7:0] act, ok, ecs;
    logic edt, ebe, ebusy;
    logic [3:0] esel;
    logic [15:0] edin;
  } vec_t;

  function automatic vec_t mk(logic r, logic a, logic u, logic l, logic b, logic [7:0] act,
                              logic [7:0] ok, logic [7:0] ecs, logic edt, logic ebe,
                              logic ebusy, logic [3:0] esel, logic [15:0] edin);
    vec_t v;
    v.rst = r; v.asn = a; v.udsn = u; v.ldsn = l; v.bgackn = b; v.act = act; v.ok = ok;
    v.ecs = ecs; v.edt = edt; v.ebe = ebe; v.ebusy = ebusy; v.esel = esel; v.edin = edin;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    idle_in();
    for (int i = 0; i < 8; i++) region_din[i*16 +: 16] = 16'h0ABC | 16'(i << 12);

    // rst ASn UDSn LDSn BGACKn active ok | cs DTACKn BERRn busy sel cpu_din
    tbl.push_back(mk(1,1,1,1,1,8'h00,8'h00, 8'h00,1,1,0,0,16'hFFFF));
    tbl.push_back(mk(0,1,1,1,1,8'h00,8'h00, 8'h00,1,1,0,0,16'hFFFF));
    tbl.push_back(mk(0,0,1,0,1,8'h08,8'h00, 8'h08,1,1,1,3,16'hFFFF));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,1,0,1,8'h08,8'h00, 8'h08,1,1,1,3,16'hFFFF));
    tbl.push_back(mk(0,0,1,0,1,8'h08,8'h08, 8'h08,0,1,1,3,16'h3ABC));
    tbl.push_back(mk(0,0,1,0,1,8'h08,8'h08, 8'h08,0,1,1,3,16'h3ABC));
    tbl.push_back(mk(0,1,1,1,1,8'h08,8'h08, 8'h00,1,1,0,3,16'h3ABC));
    tbl.push_back(mk(0,0,0,1,1,8'h0C,8'h00, 8'h04,1,1,1,2,16'h3ABC));
    tbl.push_back(mk(0,0,0,1,1,8'h0C,8'h04, 8'h04,0,1,1,2,16'h2ABC));
    tbl.push_back(mk(0,1,1,1,1,8'h0C,8'h04, 8'h00,1,1,0,2,16'h2ABC));
    tbl.push_back(mk(0,0,1,0,0,8'h02,8'h00, 8'h00,1,1,0,2,16'h2ABC));
    tbl.push_back(mk(0,0,1,0,0,8'h02,8'h00, 8'h00,1,1,0,2,16'h2ABC));
    tbl.push_back(mk(0,1,1,1,1,8'h02,8'h00, 8'h00,1,1,0,2,16'h2ABC));
    tbl.push_back(mk(0,0,1,0,1,8'h02,8'h00, 8'h02,1,1,1,1,16'h2ABC));
    tbl.push_back(mk(0,1,1,1,1,8'h02,8'h00, 8'h00,1,1,0,1,16'h2ABC));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; ASn = tbl[i].asn; UDSn = tbl[i].udsn; LDSn = tbl[i].ldsn;
      BGACKn = tbl[i].bgackn; active = tbl[i].act; region_ok = tbl[i].ok;
      cyc();
      chk($sformatf("t%0d_cs", i),    32'(cs),      32'(tbl[i].ecs));
      chk($sformatf("t%0d_dtack", i), 32'(DTACKn),  32'(tbl[i].edt));
      chk($sformatf("t%0d_berr", i),  32'(BERRn),   32'(tbl[i].ebe));
      chk($sformatf("t%0d_busy", i),  32'(busy),    32'(tbl[i].ebusy));
      chk($sformatf("t%0d_sel", i),   32'(sel),     32'(tbl[i].esel));
      chk($sformatf("t%0d_din", i),   32'(cpu_din), 32'(tbl[i].edin));
    end

    // Zero-wait region 6: DTACKn two cycles after BUSn falls, region_ok ignored.
    idle_in(); ASn = 0; LDSn = 0; active = 8'h40;
    cyc(); chk("fast_cs", 32'(cs), 32'h40); chk("fast_dt1", 32'(DTACKn), 1);
    cyc(); chk("fast_dt0", 32'(DTACKn), 0); chk("fast_din", 32'(cpu_din), 32'h6ABC);
    ASn = 1; LDSn = 1;
    cyc(); chk("fast_rel_dt", 32'(DTACKn), 1); chk("fast_rel_cs", 32'(cs), 0);

    // Unmapped access: 17 WAIT cycles then BERRn until ASn rises.
    ASn = 0; LDSn = 0; active = 8'h00;
    cyc(); chk("tout_busy", 32'(busy), 1);
    for (int k = 2; k <= 17; k++) begin
      cyc();
      chk($sformatf("tout_berr_hi%0d", k), 32'(BERRn), 1);
      chk($sformatf("tout_cs%0d", k), 32'(cs), 0);
    end
    cyc(); chk("tout_berr_lo", 32'(BERRn), 0);
    cyc(); chk("tout_berr_hold", 32'(BERRn), 0); chk("tout_busy_hold", 32'(busy), 1);
    ASn = 1; LDSn = 1;
    cyc(); chk("tout_berr_rel", 32'(BERRn), 1); chk("tout_idle", 32'(busy), 0);
    chk("tout_din", 32'(cpu_din), 32'h6ABC);

    // Read-modify-write on region 4: cs must drop between the two accesses.
    ASn = 0; LDSn = 0; active = 8'h10; region_ok = 8'h10;
    cyc(); chk("rmw_cs1", 32'(cs), 32'h10);
    cyc(); chk("rmw_dt1", 32'(DTACKn), 0); chk("rmw_din", 32'(cpu_din), 32'h4ABC);
    LDSn = 1;
    cyc(); chk("rmw_gap1_cs", 32'(cs), 0); chk("rmw_gap1_dt", 32'(DTACKn), 1);
    cyc(); chk("rmw_gap2_cs", 32'(cs), 0);
    LDSn = 0;
    cyc(); chk("rmw_cs2", 32'(cs), 32'h10); chk("rmw_dt_hi", 32'(DTACKn), 1);
    cyc(); chk("rmw_dt2", 32'(DTACKn), 0);
    ASn = 1; LDSn = 1;
    cyc(); chk("rmw_end_cs", 32'(cs), 0);

    // Reset while acknowledging.
    ASn = 0; LDSn = 0; active = 8'h08; region_ok = 8'h08;
    cyc(); cyc(); chk("rst_pre_dt", 32'(DTACKn), 0);
    rst = 1;
    cyc();
    chk("rst_cs", 32'(cs), 0); chk("rst_dt", 32'(DTACKn), 1); chk("rst_busy", 32'(busy), 0);
    chk("rst_din", 32'(cpu_din), 32'hFFFF); chk("rst_sel", 32'(sel), 0);
    idle_in();
    cyc();

    // Randomised traffic against the transaction model.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 15) ASn = ~ASn;
      if ($urandom_range(0, 9) < 3) {UDSn, LDSn} = 2'($urandom);
      BGACKn = ($urandom_range(0, 9) != 0);
      active = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      region_ok = 8'($urandom) & 8'($urandom) & 8'($urandom);
      region_din = {$urandom(), $urandom(), $urandom(), $urandom()};
      cyc();
      chk($sformatf("r%0d_cs", n),    32'(cs),      32'(m_cs));
      chk($sformatf("r%0d_din", n),   32'(cpu_din), 32'(m_din));
      chk($sformatf("r%0d_dtack", n), 32'(DTACKn),  32'(m_dtn));
      chk($sformatf("r%0d_berr", n),  32'(BERRn),   32'(m_ben));
      chk($sformatf("r%0d_sel", n),   32'(sel),     32'(m_sel));
      chk($sformatf("r%0d_busy", n),  32'(busy),    32'(m_pending || m_acked || m_errored));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
